systolic_feed_controller: RTL

SYSTOLIC_FEED_CONTROLLER -- requirements
Module: systolic_feed_controller

---
 rtl/systolic_feed_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/systolic_feed_controller.sv
// Systolic feed controller: streams num_vecs unified-buffer reads into the
// rearranger, then drains the 15-stage skew path before signalling done.
module systolic_feed_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] base_addr,
  input  logic [15:0] num_vecs,
  output logic        ubuf_rd_en,
  output logic [15:0] ubuf_rd_addr,
  output logic        load_en,
  output logic        shift_en,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DRAIN_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   rd_cnt, rd_cnt_n;
  logic [ADDR_W-1:0]   base_q, base_n;
  logic [ADDR_W-1:0]   num_q, num_n;
  logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_n;

  logic                rd_en_n;
  logic [ADDR_W-1:0]   rd_addr_n;
  logic                load_n;
  logic                shift_n;
  logic                busy_n;
  logic                done_n;
  logic                aborted_n;
  logic                abort_take;

  // State, counters, latched job and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_cnt       <= '0;
      base_q       <= '0;
      num_q        <= '0;
      drain_cnt    <= '0;
      ubuf_rd_en   <= 1'b0;
      ubuf_rd_addr <= '0;
      load_en      <= 1'b0;
      shift_en     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= state_n;
      rd_cnt       <= rd_cnt_n;
      base_q       <= base_n;
      num_q        <= num_n;
      drain_cnt    <= drain_cnt_n;
      ubuf_rd_en   <= rd_en_n;
      ubuf_rd_addr <= rd_addr_n;
      load_en      <= load_n;
      shift_en     <= shift_n;
      busy         <= busy_n;
      done         <= done_n;
      aborted      <= aborted_n;
    end
  end

  // Next state plus the values the output registers take on the same edge
  always_comb begin
    state_n     = state;
    rd_cnt_n    = rd_cnt;
    base_n      = base_q;
    num_n       = num_q;
    drain_cnt_n = drain_cnt;
    rd_en_n     = 1'b0;
    rd_addr_n   = '0;
    done_n      = 1'b0;
    aborted_n   = 1'b0;
    abort_take  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_vecs == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n   = STREAM;
            base_n    = base_addr;
            num_n     = num_vecs;
            rd_cnt_n  = '0;
            rd_en_n   = 1'b1;
            rd_addr_n = base_addr;
          end
        end
      end
      STREAM: begin
        if (rd_cnt == num_q - ADDR_W'(1)) begin
          state_n     = DRAIN;
          drain_cnt_n = '0;
        end else begin
          rd_cnt_n  = rd_cnt + ADDR_W'(1);
          rd_en_n   = 1'b1;
          rd_addr_n = base_q + rd_cnt_n;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(15)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          drain_cnt_n = drain_cnt + DRAIN_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Abort outranks every transition, including the one into DONE
    if (abort && (state != IDLE)) begin
      abort_take = 1'b1;
      state_n    = IDLE;
      rd_en_n    = 1'b0;
      rd_addr_n  = '0;
      done_n     = 1'b0;
      aborted_n  = 1'b1;
    end

    load_n  = ubuf_rd_en && !abort_take;
    shift_n = load_n || (state_n == DRAIN);
    busy_n  = (state_n != IDLE);
  end

endmodule
